// File: rtl/acondicionador_pkg.sv
// Shared types and helpers for the push-button conditioner.
// Optional auto-repeat is enabled by defining ACONDICIONADOR_AUTOREPEAT_EN.
package acondicionador_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    LONG,
    DEB_RELEASE
  } estado_t;

  // Width needed to hold the largest of the three cycle counts without wrapping.
  function automatic int ancho_contador(input int debounce, input int hold, input int repeticion);
    int maximo;
    maximo = debounce;
    if (hold > maximo) maximo = hold;
    if (repeticion > maximo) maximo = repeticion;
    return $clog2(maximo + 1);
  endfunction

endpackage

// File: rtl/acondicionador_pulsador_sincronizador.sv
// Plain flop chain that brings the asynchronous button into the clk domain.
module sincronizador #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] etapas;

  // Shift the raw input through the chain; nothing sits between stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      etapas <= '0;
    end else begin
      etapas <= {etapas[SYNC_STAGES-2:0], d};
    end
  end

  assign q = etapas[SYNC_STAGES-1];

endmodule

// File: rtl/acondicionador_pulsador.sv
// Push-button conditioner: synchronizer, debounce FSM and press/release/long pulses.
// Defining ACONDICIONADOR_AUTOREPEAT_EN adds periodic pulso_press ticks while held long.
module acondicionador_pulsador
  import acondicionador_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int HOLD_CYCLES     = 10000000,
  parameter int REPEAT_CYCLES   = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic pulsador,
  output logic nivel,
  output logic pulso_press,
  output logic pulso_release,
  output logic pulso_largo
);

  localparam int ANCHO = ancho_contador(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [ANCHO-1:0] FIN_DEBOUNCE = ANCHO'(DEBOUNCE_CYCLES - 1);
  localparam logic [ANCHO-1:0] FIN_HOLD     = ANCHO'(HOLD_CYCLES - 1);
`ifdef ACONDICIONADOR_AUTOREPEAT_EN
  localparam logic [ANCHO-1:0] FIN_REPEAT   = ANCHO'(REPEAT_CYCLES - 1);
`endif

  logic          s;
  estado_t       estado;
  logic [ANCHO-1:0] cnt;
  logic [ANCHO-1:0] cnt_hold;
  logic          origen_largo;
`ifdef ACONDICIONADOR_AUTOREPEAT_EN
  logic [ANCHO-1:0] cnt_repeat;
`endif

  function automatic logic [ANCHO-1:0] incrementar(input logic [ANCHO-1:0] v);
    return (v == '1) ? v : v + ANCHO'(1);
  endfunction

  sincronizador #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sincronizador (
    .clk(clk),
    .rst(rst),
    .d  (pulsador),
    .q  (s)
  );

  // Debounce/hold FSM with all outputs registered; pulses are cleared every cycle by default.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado        <= IDLE;
      cnt           <= '0;
      cnt_hold      <= '0;
      origen_largo  <= 1'b0;
      nivel         <= 1'b0;
      pulso_press   <= 1'b0;
      pulso_release <= 1'b0;
      pulso_largo   <= 1'b0;
`ifdef ACONDICIONADOR_AUTOREPEAT_EN
      cnt_repeat    <= '0;
`endif
    end else begin
      pulso_press   <= 1'b0;
      pulso_release <= 1'b0;
      pulso_largo   <= 1'b0;
      case (estado)
        IDLE: begin
          nivel <= 1'b0;
          if (s) begin
            estado <= DEB_PRESS;
            cnt    <= '0;
          end
        end
        DEB_PRESS: begin
          if (!s) begin
            estado <= IDLE;
          end else begin
            cnt <= incrementar(cnt);
            if (incrementar(cnt) >= FIN_DEBOUNCE) begin
              estado       <= PRESSED;
              cnt_hold     <= '0;
              origen_largo <= 1'b0;
              nivel        <= 1'b1;
              pulso_press  <= 1'b1;
            end
          end
        end
        PRESSED: begin
          cnt_hold <= incrementar(cnt_hold);
          if (!s) begin
            estado <= DEB_RELEASE;
            cnt    <= '0;
          end else if (cnt_hold >= FIN_HOLD) begin
            estado       <= LONG;
            origen_largo <= 1'b1;
            pulso_largo  <= 1'b1;
`ifdef ACONDICIONADOR_AUTOREPEAT_EN
            cnt_repeat   <= '0;
`endif
          end
        end
        LONG: begin
          if (!s) begin
            estado <= DEB_RELEASE;
            cnt    <= '0;
`ifdef ACONDICIONADOR_AUTOREPEAT_EN
            cnt_repeat <= incrementar(cnt_repeat);
          end else if (cnt_repeat >= FIN_REPEAT) begin
            cnt_repeat  <= '0;
            pulso_press <= 1'b1;
          end else begin
            cnt_repeat <= incrementar(cnt_repeat);
`endif
          end
        end
        DEB_RELEASE: begin
          if (s) begin
            estado <= origen_largo ? LONG : PRESSED;
          end else begin
            cnt <= incrementar(cnt);
            if (incrementar(cnt) >= FIN_DEBOUNCE) begin
              estado        <= IDLE;
              origen_largo  <= 1'b0;
              nivel         <= 1'b0;
              pulso_release <= 1'b1;
`ifdef ACONDICIONADOR_AUTOREPEAT_EN
              cnt_repeat    <= '0;
`endif
            end
          end
        end
        default: begin
          estado <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acondicionador_pulsador.sv
// Self-checking bench for acondicionador_pulsador (behaves per ACONDICIONADOR_AUTOREPEAT_EN).
module tb_acondicionador_pulsador;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pulsador = 1'b0;
  logic nivel, pulso_press, pulso_release, pulso_largo;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int n_press = 0, n_release = 0, n_largo = 0, n_nivel_high = 0;
  int last_press = 0, last_release = 0, last_largo = 0;
  logic nivel_at_release = 1'b1;

  logic [SYNC-1:0] m_sync;
  bit m_level, m_long, m_valid = 1'b0;
  int m_run, m_held, m_rep;
  bit exp_nivel, exp_press, exp_release, exp_largo;

  acondicionador_pulsador #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pulsador     (pulsador),
    .nivel        (nivel),
    .pulso_press  (pulso_press),
    .pulso_release(pulso_release),
    .pulso_largo  (pulso_largo)
  );

  // Free-running clock and cycle index.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d cycle=%0d", name, actual, expected, cyc);
    end
  endtask

  task automatic step(input logic v);
    @(posedge clk);
    #1;
    pulsador = v;
  endtask

  task automatic applyStimulus(input logic v, input int n);
    repeat (n) step(v);
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Behavioural model: a run of DEB opposing samples flips the accepted level;
  // steady pressed cycles accumulate toward the long press and the repeat period.
  always @(posedge clk) begin : modelo
    bit s, firm, was_long, lvl, lng, p, r, l;
    int run, held, rep;
    if (rst) begin
      m_sync      <= '0;
      m_level     <= 1'b0;
      m_long      <= 1'b0;
      m_run       <= 0;
      m_held      <= 0;
      m_rep       <= 0;
      exp_nivel   <= 1'b0;
      exp_press   <= 1'b0;
      exp_release <= 1'b0;
      exp_largo   <= 1'b0;
      m_valid     <= 1'b1;
    end else if (m_valid) begin
      s = m_sync[SYNC-1];
      lvl = m_level;
      lng = m_long;
      run = m_run;
      held = m_held;
      rep = m_rep;
      p = 1'b0;
      r = 1'b0;
      l = 1'b0;
      firm = lvl && (run == 0);
      was_long = lng;
      if (firm && !lng) held++;
      if (firm && lng) rep++;
      if (s != lvl) run++;
      else run = 0;
      if (run == DEB) begin
        lvl = !lvl;
        run = 0;
        lng = 1'b0;
        rep = 0;
        if (lvl) begin
          p = 1'b1;
          held = 0;
        end else begin
          r = 1'b1;
        end
      end else if (firm && s && !was_long && held >= HOLD) begin
        lng = 1'b1;
        l = 1'b1;
        rep = 0;
      end
`ifdef ACONDICIONADOR_AUTOREPEAT_EN
      else if (firm && s && was_long && rep >= REP) begin
        p = 1'b1;
        rep = 0;
      end
`endif
      m_level     <= lvl;
      m_long      <= lng;
      m_run       <= run;
      m_held      <= held;
      m_rep       <= rep;
      exp_nivel   <= lvl;
      exp_press   <= p;
      exp_release <= r;
      exp_largo   <= l;
      m_sync      <= {m_sync[SYNC-2:0], pulsador};
    end
  end

  // Compare every cycle against the model and log pulse events for the directed checks.
  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("nivel", {31'd0, nivel}, {31'd0, exp_nivel});
      checkOutput("pulso_press", {31'd0, pulso_press}, {31'd0, exp_press});
      checkOutput("pulso_release", {31'd0, pulso_release}, {31'd0, exp_release});
      checkOutput("pulso_largo", {31'd0, pulso_largo}, {31'd0, exp_largo});
      if (pulso_press === 1'b1) begin
        n_press    <= n_press + 1;
        last_press <= cyc;
      end
      if (pulso_release === 1'b1) begin
        n_release        <= n_release + 1;
        last_release     <= cyc;
        nivel_at_release <= nivel;
      end
      if (pulso_largo === 1'b1) begin
        n_largo    <= n_largo + 1;
        last_largo <= cyc;
      end
      if (nivel === 1'b1) n_nivel_high <= n_nivel_high + 1;
    end
  end

  // Watchdog so the run always ends with a summary.
  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog timeout cycle=%0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios with hand-computed timings, then randomized button activity.
  initial begin
    int e, p0, r0, l0, h0, len;
    logic v;
    rst = 1'b1;
    pulsador = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_nivel", {31'd0, nivel}, 0);
    checkOutput("reset_press", {31'd0, pulso_press}, 0);
    checkOutput("reset_release", {31'd0, pulso_release}, 0);
    checkOutput("reset_largo", {31'd0, pulso_largo}, 0);

    $display("[TB] clean press");
    applyStimulus(1'b0, 5);
    p0 = n_press; r0 = n_release; l0 = n_largo;
    step(1'b1);
    e = cyc;
    applyStimulus(1'b1, 12);
    checkOutput("t1_press_latency", last_press - e, 6);
    checkOutput("t1_press_count", n_press - p0, 1);
    checkOutput("t1_other_pulses", (n_release - r0) + (n_largo - l0), 0);
    checkOutput("t1_nivel", {31'd0, nivel}, 1);
    applyStimulus(1'b0, 15);

    $display("[TB] press bounce");
    p0 = n_press;
    step(1'b1); step(1'b0); step(1'b1); step(1'b0); step(1'b1);
    e = cyc;
    applyStimulus(1'b1, 11);
    checkOutput("t2_press_count", n_press - p0, 1);
    checkOutput("t2_press_latency", last_press - e, 6);

    $display("[TB] release bounce");
    p0 = n_press; r0 = n_release; l0 = n_largo;
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 2);
    step(1'b0);
    e = cyc;
    applyStimulus(1'b0, 13);
    checkOutput("t3_release_count", n_release - r0, 1);
    checkOutput("t3_release_latency", last_release - e, 6);
    checkOutput("t3_nivel_at_release", {31'd0, nivel_at_release}, 0);
    checkOutput("t3_no_press_largo", (n_press - p0) + (n_largo - l0), 0);

    $display("[TB] long press");
    p0 = n_press; r0 = n_release; l0 = n_largo;
    step(1'b1);
    e = cyc;
    applyStimulus(1'b1, 45);
    checkOutput("t4_largo_count", n_largo - l0, 1);
    checkOutput("t4_largo_latency", last_largo - e, 26);
`ifdef ACONDICIONADOR_AUTOREPEAT_EN
    checkOutput("t4_press_count", n_press - p0, 3);
    checkOutput("t4_last_repeat", last_press - e, 42);
`else
    checkOutput("t4_press_count", n_press - p0, 1);
    checkOutput("t4_last_press", last_press - e, 6);
`endif
    applyStimulus(1'b0, 15);
    checkOutput("t4_release_count", n_release - r0, 1);

    $display("[TB] reset mid-press");
    p0 = n_press; r0 = n_release;
    step(1'b1);
    applyStimulus(1'b1, 10);
    pulseReset();
    e = cyc;
    @(negedge clk);
    checkOutput("t5_nivel_after_reset", {31'd0, nivel}, 0);
    checkOutput("t5_press_after_reset", {31'd0, pulso_press}, 0);
    applyStimulus(1'b1, 10);
    checkOutput("t5_repress_latency", last_press - e, 6);
    checkOutput("t5_press_count", n_press - p0, 2);
    checkOutput("t5_no_release", n_release - r0, 0);
    applyStimulus(1'b0, 15);

    $display("[TB] glitch rejection");
    p0 = n_press; r0 = n_release; l0 = n_largo; h0 = n_nivel_high;
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 15);
    checkOutput("t6_no_pulses", (n_press - p0) + (n_release - r0) + (n_largo - l0), 0);
    checkOutput("t6_nivel_low", n_nivel_high - h0, 0);

    $display("[TB] random activity");
    v = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 99) < 3) pulseReset();
      v = ~v;
      if ($urandom_range(0, 2) == 0) len = $urandom_range(1, 5);
      else len = $urandom_range(4, 60);
      applyStimulus(v, len);
    end
    applyStimulus(1'b0, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
